alu_req_server: RTL and testbench

Sequential request/response front end for the 8-bit `alu`. It plays the responder for an initiator that issues operations, replacing the free-running "drive select, wait, sample" style of stimulus. It accepts operations over a valid/ready request channel and drives the registered operands into an external `alu` instance. After a programmable settle delay it captures `result` and `flag`, and queues them, tagged with a sequence number, in a response FIFO with its own valid/ready channel.

---
 rtl/alu_req_server.sv | 132 +++++++++++++
 tb/tb_alu_req_server.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_server.sv
// Request/response front end for an external 8-bit ALU. It registers the operands, waits
// SETTLE cycles, captures result/flag and queues them with a sequence tag.
`timescale 1ns/1ps
module alu_req_server #(
  parameter int SETTLE = 1,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_val1,
  input  logic [7:0] req_val2,
  input  logic [3:0] req_select,
  output logic [7:0] alu_val1,
  output logic [7:0] alu_val2,
  output logic [3:0] alu_select,
  input  logic [7:0] alu_result,
  input  logic       alu_flag,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_flag,
  output logic [7:0] rsp_tag,
  output logic       busy
);

  localparam int             PW        = $clog2(DEPTH);
  localparam logic [PW:0]    FULL_CNT  = (PW+1)'(DEPTH);
  localparam logic [3:0]     WAIT_INIT = 4'(SETTLE - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic [7:0] result;
    logic       flag;
    logic [7:0] tag;
  } rsp_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_wait_cnt;
  logic [7:0]    r_tag_ctr;
  logic [7:0]    r_cur_tag;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  rsp_t          r_mem [DEPTH];
  rsp_t          w_head;
  logic          w_accept;
  logic          w_capture;
  logic          w_pop;
  logic          w_fifo_full;

  assign w_fifo_full = (r_count == FULL_CNT);
  assign w_accept    = req_valid && req_ready;
  assign w_capture   = (r_state == S_WAIT) && (r_wait_cnt == 4'd0);
  assign rsp_valid   = (r_count != '0);
  assign w_pop       = rsp_valid && rsp_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: each always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next_state = S_WAIT;
      S_WAIT:  if (w_capture) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE:  req_ready = !w_fifo_full;
      S_WAIT:  busy      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_val1   <= '0;
      alu_val2   <= '0;
      alu_select <= '0;
      r_wait_cnt <= '0;
      r_tag_ctr  <= '0;
      r_cur_tag  <= '0;
    end else if (w_accept) begin
      alu_val1   <= req_val1;
      alu_val2   <= req_val2;
      alu_select <= req_select;
      r_wait_cnt <= WAIT_INIT;
      r_cur_tag  <= r_tag_ctr;
      r_tag_ctr  <= r_tag_ctr + 8'd1;
    end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  // Pointers wrap naturally; a push only happens with a free slot, so no overflow guard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_capture) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      if (w_capture && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_capture && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // NOTE: storage is not reset; pointers and occupancy alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_capture && !rst) r_mem[r_wptr] <= '{result: alu_result, flag: alu_flag, tag: r_cur_tag};
  end

  // Head is zeroed while empty so the outputs are defined straight out of reset.
  assign w_head     = r_mem[r_rptr];
  assign rsp_result = rsp_valid ? w_head.result : '0;
  assign rsp_flag   = rsp_valid ? w_head.flag   : 1'b0;
  assign rsp_tag    = rsp_valid ? w_head.tag    : '0;

endmodule

// File: tb/tb_alu_req_server.sv
// Directed bench for alu_req_server: two instances (SETTLE=1 and SETTLE=3) share the stimulus,
// a behavioural ALU closes the loop, and a scoreboard checks every response in tag order.
`timescale 1ns/1ps
module tb_alu_req_server;

  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s);
    logic [8:0]  w;
    logic [15:0] m;
    logic [7:0]  r;
    logic        f;
    w = '0; m = '0; r = '0; f = 1'b0;
    case (s)
      4'd0:  begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; f = w[8]; end
      4'd1:  begin r = a - b; f = (a < b); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~a;
      4'd6:  begin r = {a[6:0], 1'b0}; f = a[7]; end
      4'd7:  begin r = {1'b0, a[7:1]}; f = a[0]; end
      4'd8:  begin r = a + 8'd1; f = (a == 8'hFF); end
      4'd9:  begin r = a - 8'd1; f = (a == 8'h00); end
      4'd10: begin m = a * b; r = m[7:0]; f = (m[15:8] != 8'h00); end
      4'd11: f = (a == b);
      4'd12: f = (a < b);
      4'd13: r = b;
      4'd14: r = {a[6:0], a[7]};
      default: r = (a > b) ? a : b;
    endcase
    if (s inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd13, 4'd14, 4'd15}) f = (r == 8'h00);
    return {f, r};
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req_valid, rsp_ready, use3;
  logic [7:0] req_val1, req_val2;
  logic [3:0] req_select;

  logic       req_ready_a, busy_a, rsp_valid_a, rsp_flag_a, alu_flag_a;
  logic [7:0] alu_val1_a, alu_val2_a, alu_result_a, rsp_result_a, rsp_tag_a;
  logic [3:0] alu_select_a;
  logic       req_ready_b, busy_b, rsp_valid_b, rsp_flag_b, alu_flag_b;
  logic [7:0] alu_val1_b, alu_val2_b, alu_result_b, rsp_result_b, rsp_tag_b;
  logic [3:0] alu_select_b;

  assign {alu_flag_a, alu_result_a} = alu_ref(alu_val1_a, alu_val2_a, alu_select_a);
  assign {alu_flag_b, alu_result_b} = alu_ref(alu_val1_b, alu_val2_b, alu_select_b);

  alu_req_server #(.SETTLE(1), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_val1(req_val1), .req_val2(req_val2), .req_select(req_select),
    .alu_val1(alu_val1_a), .alu_val2(alu_val2_a), .alu_select(alu_select_a),
    .alu_result(alu_result_a), .alu_flag(alu_flag_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_result(rsp_result_a),
    .rsp_flag(rsp_flag_a), .rsp_tag(rsp_tag_a), .busy(busy_a));

  alu_req_server #(.SETTLE(3), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_val1(req_val1), .req_val2(req_val2), .req_select(req_select),
    .alu_val1(alu_val1_b), .alu_val2(alu_val2_b), .alu_select(alu_select_b),
    .alu_result(alu_result_b), .alu_flag(alu_flag_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_result(rsp_result_b),
    .rsp_flag(rsp_flag_b), .rsp_tag(rsp_tag_b), .busy(busy_b));

  // Observed instance
  logic       req_ready_o, busy_o, rsp_valid_o, rsp_flag_o;
  logic [7:0] rsp_result_o, rsp_tag_o, alu_val1_o, alu_val2_o;
  logic [3:0] alu_select_o;
  assign req_ready_o  = use3 ? req_ready_b  : req_ready_a;
  assign busy_o       = use3 ? busy_b       : busy_a;
  assign rsp_valid_o  = use3 ? rsp_valid_b  : rsp_valid_a;
  assign rsp_flag_o   = use3 ? rsp_flag_b   : rsp_flag_a;
  assign rsp_result_o = use3 ? rsp_result_b : rsp_result_a;
  assign rsp_tag_o    = use3 ? rsp_tag_b    : rsp_tag_a;
  assign alu_val1_o   = use3 ? alu_val1_b   : alu_val1_a;
  assign alu_val2_o   = use3 ? alu_val2_b   : alu_val2_a;
  assign alu_select_o = use3 ? alu_select_b : alu_select_a;

  typedef struct packed {
    logic [7:0] result;
    logic       flag;
    logic [7:0] tag;
  } exp_t;

  exp_t       exp_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         last_acc = 0;
  int         n_rsp    = 0;
  int         max_occ  = 0;
  logic [7:0] tag_model = 8'h00;
  logic [7:0] last_tag  = 8'h00;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: push at acceptance, pop/compare at response handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      tag_model = 8'h00;
    end else begin
      int         occ;
      logic [8:0] r;
      exp_t       e;
      occ = exp_q.size() - ((busy_o === 1'b1) ? 1 : 0);
      if (occ > max_occ) max_occ = occ;
      if (rsp_valid_o === 1'b1 && rsp_ready) begin
        check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_tag", 32'(rsp_tag_o), 32'(e.tag));
          check("rsp_result", 32'(rsp_result_o), 32'(e.result));
          check("rsp_flag", 32'(rsp_flag_o), 32'(e.flag));
        end
        n_rsp++;
        last_tag = rsp_tag_o;
      end
      if (req_valid && req_ready_o === 1'b1) begin
        r = alu_ref(req_val1, req_val2, req_select);
        exp_q.push_back('{result: r[7:0], flag: r[8], tag: tag_model});
        tag_model = tag_model + 8'd1;
        last_acc  = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Returns just after the acceptance edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic accepted;
    req_val1 = a; req_val2 = b; req_select = s; req_valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 64 && !accepted; k++) begin
      @(negedge clk);
      if (req_ready_o === 1'b1) accepted = 1'b1;
    end
    check("send_accepted", 32'(accepted), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, prev;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; use3 = 1'b0;
    req_val1 = '0; req_val2 = '0; req_select = '0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      req_valid  = 1'($urandom);
      req_val1   = 8'($urandom);
      req_val2   = 8'($urandom);
      req_select = 4'($urandom);
      rsp_ready  = 1'($urandom);
      tick();
    end
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_alu_val1", 32'(alu_val1_o), 32'h00);
    check("rst_alu_val2", 32'(alu_val2_o), 32'h00);
    check("rst_alu_select", 32'(alu_select_o), 32'h0);
    check("rst_rsp_tag", 32'(rsp_tag_o), 32'h00);
    check("rst_b_req_ready", 32'(req_ready_b), 32'd1);

    // Single add, SETTLE=1
    rsp_ready = 1'b1;
    send(8'h0A, 8'h02, 4'd0);
    check("add_busy_a", 32'(busy_o), 32'd1);
    check("add_valid_a", 32'(rsp_valid_o), 32'd0);
    check("add_alu_val1", 32'(alu_val1_o), 32'h0A);
    tick();
    check("add_valid_a1", 32'(rsp_valid_o), 32'd1);
    check("add_result", 32'(rsp_result_o), 32'h0C);
    check("add_flag", 32'(rsp_flag_o), 32'd0);
    check("add_tag", 32'(rsp_tag_o), 32'h00);
    check("add_busy_a1", 32'(busy_o), 32'd0);
    tick();
    check("add_valid_a2", 32'(rsp_valid_o), 32'd0);
    check("add_busy_a2", 32'(busy_o), 32'd0);

    // Select sweep at SETTLE=1 then SETTLE=3
    for (int inst = 0; inst < 2; inst++) begin
      rst = 1'b1; use3 = 1'(inst); tick(); rst = 1'b0;
      n0 = n_rsp; prev = 0; rsp_ready = 1'b1;
      for (int s = 0; s < 16; s++) begin
        send(8'h0A, 8'h02, 4'(s));
        if (s > 0) check(inst == 0 ? "spacing_s1" : "spacing_s3", 32'(last_acc - prev),
                         inst == 0 ? 32'd2 : 32'd4);
        prev = last_acc;
      end
      drain();
      check("sweep_count", 32'(n_rsp - n0), 32'd16);
      check("sweep_last_tag", 32'(last_tag), 32'h0F);
    end
    rst = 1'b1; use3 = 1'b0; tick(); rst = 1'b0;

    // Backpressure
    rsp_ready = 1'b0; n0 = n_rsp;
    for (int i = 0; i < 4; i++) send(8'(i + 1), 8'h10, 4'd0);
    req_val1 = 8'h55; req_val2 = 8'h01; req_select = 4'd0; req_valid = 1'b1;
    tick();
    check("bp_full_ready", 32'(req_ready_o), 32'd0);
    check("bp_full_valid", 32'(rsp_valid_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready_held_low", 32'(req_ready_o), 32'd0);
      check("bp_not_busy", 32'(busy_o), 32'd0);
    end
    check("bp_head_tag", 32'(rsp_tag_o), 32'h00);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_popped_one", 32'(n_rsp - n0), 32'd1);
    check("bp_ready_after_pop", 32'(req_ready_o), 32'd1);
    tick();
    req_valid = 1'b0;
    check("bp_fifth_accepted", 32'(busy_o), 32'd1);
    tick();
    drain();
    check("bp_count", 32'(n_rsp - n0), 32'd5);
    check("bp_last_tag", 32'(last_tag), 32'h04);

    // Tag wrap with simultaneous push/pop
    reset_dut();
    rsp_ready = 1'b1; max_occ = 0; n0 = n_rsp;
    for (int i = 0; i < 257; i++) send(8'(i), 8'(~i), 4'(i % 16));
    drain();
    check("wrap_count", 32'(n_rsp - n0), 32'd257);
    check("wrap_last_tag", 32'(last_tag), 32'h00);
    check("wrap_max_occ_le1", 32'(max_occ <= 1), 32'd1);

    // Reset mid-operation
    reset_dut();
    rsp_ready = 1'b0;
    send(8'h01, 8'h01, 4'd0);
    send(8'h02, 8'h02, 4'd0);
    send(8'h03, 8'h03, 4'd0);
    check("mid_busy_pre", 32'(busy_o), 32'd1);
    check("mid_valid_pre", 32'(rsp_valid_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_valid_post", 32'(rsp_valid_o), 32'd0);
    check("mid_busy_post", 32'(busy_o), 32'd0);
    check("mid_ready_post", 32'(req_ready_o), 32'd1);
    tick();
    tick();
    check("mid_no_capture", 32'(rsp_valid_o), 32'd0);
    rsp_ready = 1'b1;
    send(8'h03, 8'h04, 4'd0);
    tick();
    check("mid_next_valid", 32'(rsp_valid_o), 32'd1);
    check("mid_next_tag", 32'(rsp_tag_o), 32'h00);
    check("mid_next_result", 32'(rsp_result_o), 32'h07);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
